// File: rtl/jcr8_imem_pkg.sv
// Shared types for the jacaranda-8 IMEM load path.
//   IMEM_AW / IMEM_DW : IMEM write port address / data widths
//   WR_CNT_W          : width of the per-session write counter
//   ld_state_e        : load-session FSM states
//   imem_wr_t         : one buffered write {addr, data}
package jcr8_imem_pkg;

    localparam int IMEM_AW  = 8;
    localparam int IMEM_DW  = 8;
    localparam int WR_CNT_W = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2
    } ld_state_e;

    typedef struct packed {
        logic [IMEM_AW-1:0] addr;
        logic [IMEM_DW-1:0] data;
    } imem_wr_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [WR_CNT_W-1:0] sat_inc(input logic [WR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/imem_req_fifo.sv
// Small per-requester FIFO for IMEM write requests.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push_i     : store din_i if there is room (or the head is leaving this cycle)
//   din_i      : entry to store
//   pop_i      : consume the head entry (ignored when empty)
//   head_o     : current head entry, valid while !empty_o
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   drop_o     : push_i was refused this cycle
module imem_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head is popped in the same cycle.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign drop_o  = push_i & ~push_ok;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares the IMEM write port between the Wishbone host path (req 0) and the
// UART boot loader (req 1). Each source is buffered, grants are round-robin,
// and a load session holds the core in reset while IMEM is being rewritten.
//   clk, reset              : clock, synchronous active-high reset
//   wb_req/addr/data        : one-cycle write request from Wishbone
//   uart_req/addr/data      : one-cycle write request from the UART loader
//   ovf_clr                 : clears both sticky overflow flags
//   imem_we/addr/wdata      : registered IMEM write port
//   cpu_hold                : core held in reset (LOAD and RELEASE)
//   cpu_restart             : one-cycle pulse as a session ends
//   busy                    : session FSM not idle
//   wb_ovf / uart_ovf       : sticky, a request was dropped on a full FIFO
//   wr_count                : writes issued this/last session, saturating
module imem_load_arbiter
    import jcr8_imem_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int IDLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wb_req,
    input  logic [IMEM_AW-1:0]  wb_addr,
    input  logic [IMEM_DW-1:0]  wb_data,
    input  logic                uart_req,
    input  logic [IMEM_AW-1:0]  uart_addr,
    input  logic [IMEM_DW-1:0]  uart_data,
    input  logic                ovf_clr,
    output logic                imem_we,
    output logic [IMEM_AW-1:0]  imem_addr,
    output logic [IMEM_DW-1:0]  imem_wdata,
    output logic                cpu_hold,
    output logic                cpu_restart,
    output logic                busy,
    output logic                wb_ovf,
    output logic                uart_ovf,
    output logic [WR_CNT_W-1:0] wr_count
);

    localparam int                IDLE_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    imem_wr_t wb_in, ua_in, wb_head, ua_head, win;
    logic     wb_full, wb_empty, wb_drop, ua_full, ua_empty, ua_drop;
    logic     grant_wb, grant_ua, grant;

    ld_state_e            state_q, state_d;
    logic [IDLE_W-1:0]    idle_q, idle_d;
    logic [WR_CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic                 rr_last_ua_q;
    logic                 we_q, wb_ovf_q, ua_ovf_q;
    logic [IMEM_AW-1:0]   addr_q;
    logic [IMEM_DW-1:0]   wdata_q;

    assign wb_in = '{addr: wb_addr,   data: wb_data};
    assign ua_in = '{addr: uart_addr, data: uart_data};

    imem_req_fifo #(.DEPTH(DEPTH), .W($bits(imem_wr_t))) u_wb_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wb_req),
        .din_i   (wb_in),
        .pop_i   (grant_wb),
        .head_o  (wb_head),
        .full_o  (wb_full),
        .empty_o (wb_empty),
        .drop_o  (wb_drop)
    );

    imem_req_fifo #(.DEPTH(DEPTH), .W($bits(imem_wr_t))) u_ua_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (uart_req),
        .din_i   (ua_in),
        .pop_i   (grant_ua),
        .head_o  (ua_head),
        .full_o  (ua_full),
        .empty_o (ua_empty),
        .drop_o  (ua_drop)
    );

    // Round-robin: on contention the source not granted last wins.
    always_comb begin
        grant_wb = 1'b0;
        grant_ua = 1'b0;
        if (state_q == LOAD) begin
            if (!wb_empty && (ua_empty || rr_last_ua_q)) grant_wb = 1'b1;
            else if (!ua_empty)                           grant_ua = 1'b1;
        end
    end

    assign grant = grant_wb | grant_ua;
    assign win   = grant_wb ? wb_head : ua_head;

    // Session FSM. The idle counter only advances on cycles with nothing
    // buffered and nothing arriving, so any late request extends the session.
    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            IDLE: begin
                if (!wb_empty || !ua_empty) begin
                    state_d  = LOAD;
                    wr_cnt_d = '0;
                    idle_d   = '0;
                end
            end
            LOAD: begin
                if (grant) wr_cnt_d = sat_inc(wr_cnt_q);
                if (wb_empty && ua_empty && !wb_req && !uart_req) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = RELEASE;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end else begin
                    idle_d = '0;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idle_q       <= '0;
            wr_cnt_q     <= '0;
            rr_last_ua_q <= 1'b1;   // WB wins the first contended grant
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wb_ovf_q     <= 1'b0;
            ua_ovf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            wr_cnt_q <= wr_cnt_d;
            if (grant) rr_last_ua_q <= grant_ua;
            we_q <= grant;
            if (grant) begin
                addr_q  <= win.addr;
                wdata_q <= win.data;
            end
            // A new drop beats a simultaneous clear.
            if (wb_drop)      wb_ovf_q <= 1'b1;
            else if (ovf_clr) wb_ovf_q <= 1'b0;
            if (ua_drop)      ua_ovf_q <= 1'b1;
            else if (ovf_clr) ua_ovf_q <= 1'b0;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign cpu_hold    = (state_q != IDLE);
    assign busy        = (state_q != IDLE);
    assign cpu_restart = (state_q == RELEASE);
    assign wb_ovf      = wb_ovf_q;
    assign uart_ovf    = ua_ovf_q;
    assign wr_count    = wr_cnt_q;

endmodule
